// File: rtl/rtc_id_if.sv
// APB read/write bus for the RTC identification space (0xFE0-0xFFC).
// paddr carries word address bits [11:2]; prdata is zero whenever the space is not read.
interface rtc_id_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [9:0]  paddr;
   logic [31:0] prdata;

   modport master (output psel, output penable, output pwrite, output paddr, input prdata);
   modport slave  (input psel, input penable, input pwrite, input paddr, output prdata);
endinterface

// File: rtl/rtc_id_reader.sv
// Samples the revision tie-off once after reset (majority of 3) and serves PeriphID0-3/PCellID0-3.
// Optional sticky write-error flag, reported in 0xFEC bit 8, is enabled by defining RTC_ID_WRERR_EN.
module rtc_id_reader #(
   parameter int          SETTLE_CYCLES = 16,
   parameter logic [3:0]  REV_BASE      = 4'h0,
   parameter logic [11:0] PART_NUM      = 12'h031,
   parameter logic [7:0]  DESIGNER      = 8'h41
) (
   input  logic     i_pclk,
   input  logic     i_presetn,
   input  logic     i_revision,
   rtc_id_if.slave  bus,
`ifdef RTC_ID_WRERR_EN
   output logic     o_wr_err,
`endif
   output logic     o_rev_valid
);

   localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

   typedef enum logic [1:0] {ST_SETTLE, ST_SAMPLE, ST_LOCK} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_scnt, w_scnt_nxt;
   logic [1:0]    r_smp;
   logic          r_sync1, r_sync2;
   logic          r_latch;
   logic          r_rev_valid;
   logic [31:0]   r_prdata;
   logic [31:0]   w_rdata;
   logic          w_lock;
   logic          w_sample;
   logic          w_maj;
   logic          w_setup_rd;
   logic          w_in_win;

   // Revision is a tie-off from another domain of logic; treat it as asynchronous.
   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_revision;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_state <= ST_SETTLE;
         r_cnt   <= '0;
         r_scnt  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_scnt  <= w_scnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_scnt_nxt  = r_scnt;
      w_lock      = 1'b0;
      w_sample    = 1'b0;
      case (r_state)
         ST_SETTLE: begin
            if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
               w_state_nxt = ST_SAMPLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         ST_SAMPLE: begin
            w_sample = 1'b1;
            if (r_scnt == 2'd2) begin
               w_state_nxt = ST_LOCK;
               w_lock      = 1'b1;
            end else begin
               w_scnt_nxt  = r_scnt + 2'd1;
            end
         end
         ST_LOCK:  w_state_nxt = ST_LOCK;
         default:  w_state_nxt = ST_SETTLE;
      endcase
   end

   // Third sample is taken straight from the synchroniser in the locking cycle.
   assign w_maj = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_sync2) | (r_smp[0] & r_sync2);

   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_smp       <= 2'b00;
         r_latch     <= 1'b0;
         r_rev_valid <= 1'b0;
      end else begin
         if (w_sample) r_smp <= {r_smp[0], r_sync2};
         if (w_lock) begin
            r_latch     <= w_maj;
            r_rev_valid <= 1'b1;
         end
      end
   end

`ifdef RTC_ID_WRERR_EN
   logic r_wr_err;
   logic w_wr_set, w_wr_clr;

   assign w_wr_set = bus.psel & bus.penable & bus.pwrite;
   assign w_wr_clr = bus.psel & bus.penable & ~bus.pwrite & (bus.paddr == 10'h3FB);

   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn)    r_wr_err <= 1'b0;
      else if (w_wr_set) r_wr_err <= 1'b1;
      else if (w_wr_clr) r_wr_err <= 1'b0;
   end

   assign o_wr_err = r_wr_err;
`endif

   assign w_setup_rd = bus.psel & ~bus.penable & ~bus.pwrite;
   assign w_in_win   = (bus.paddr[9:3] == 7'h7F);

   always_comb begin
      w_rdata = 32'h0;
      if (w_in_win) begin
         case (bus.paddr[2:0])
            3'd0: w_rdata[7:0] = PART_NUM[7:0];
            3'd1: w_rdata[7:0] = {DESIGNER[3:0], PART_NUM[11:8]};
            3'd2: w_rdata[7:0] = {REV_BASE[3:1], r_latch, DESIGNER[7:4]};
`ifdef RTC_ID_WRERR_EN
            3'd3: w_rdata[8]   = r_wr_err;
`else
            3'd3: w_rdata[7:0] = 8'h00;
`endif
            3'd4: w_rdata[7:0] = 8'h0D;
            3'd5: w_rdata[7:0] = 8'hF0;
            3'd6: w_rdata[7:0] = 8'h05;
            3'd7: w_rdata[7:0] = 8'hB1;
            default: w_rdata = 32'h0;
         endcase
      end
   end

   // Loaded only in a read setup phase, so it is visible exactly in the enable phase.
   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn)      r_prdata <= 32'h0;
      else if (w_setup_rd) r_prdata <= w_rdata;
      else                 r_prdata <= 32'h0;
   end

   assign bus.prdata  = r_prdata;
   assign o_rev_valid = r_rev_valid;

endmodule

// File: tb/tb_rtc_id_reader.sv
// Directed bench for rtc_id_reader: revision lock timing, glitch voting, ID map, writes, reset.
module tb_rtc_id_reader;
   logic clk = 1'b0;
   logic rst_n;
   logic rev;
   logic rv;
`ifdef RTC_ID_WRERR_EN
   logic wr_err;
`endif
   int   n_cmp = 0;
   int   n_err = 0;
   int   n;

   rtc_id_if bus ();

   rtc_id_reader dut (
      .i_pclk      (clk),
      .i_presetn   (rst_n),
      .i_revision  (rev),
      .bus         (bus),
`ifdef RTC_ID_WRERR_EN
      .o_wr_err    (wr_err),
`endif
      .o_rev_valid (rv)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = 10'h0;
   endtask

   // Two cycles: check data in the enable phase, then zero in the following cycle.
   task automatic apb_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = addr[11:2];
      cyc();
      bus.penable = 1'b1;
      chk(tag, bus.prdata, exp);
      cyc();
      bus_idle();
      chk({tag, "_after"}, bus.prdata, 32'h0);
   endtask

   task automatic apb_write(input string tag, input logic [11:0] addr);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b1;
      bus.paddr   = addr[11:2];
      cyc();
      bus.penable = 1'b1;
      chk({tag, "_setup"}, bus.prdata, 32'h0);
      cyc();
      chk({tag, "_enable"}, bus.prdata, 32'h0);
      bus_idle();
   endtask

   // Reset released #1 after an edge; the next edge is cycle 1.
   task automatic do_reset(input logic r);
      rst_n = 1'b0;
      rev   = r;
      bus_idle();
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   task automatic wait_rv(input int start, output int cnt);
      cnt = start;
      while (!rv && cnt < 60) begin
         cyc();
         cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rev   = 1'b0;
      bus_idle();
      #2;
      chk("reset_prdata", bus.prdata, 32'h0);
      chk("reset_rv", 32'(rv), 32'h0);

      // Lock timing with Revision=1
      do_reset(1'b1);
      repeat (18) cyc();
      chk("rv_cycle18", 32'(rv), 32'h0);
      cyc();
      chk("rv_cycle19", 32'(rv), 32'h1);
      apb_read("fe8_rev1", 12'hFE8, 32'h14);

      // Full ID map, back-to-back transfers
      apb_read("fe0", 12'hFE0, 32'h31);
      apb_read("fe4", 12'hFE4, 32'h10);
      apb_read("fe8", 12'hFE8, 32'h14);
      apb_read("fec", 12'hFEC, 32'h00);
      apb_read("ff0", 12'hFF0, 32'h0D);
      apb_read("ff4", 12'hFF4, 32'hF0);
      apb_read("ff8", 12'hFF8, 32'h05);
      apb_read("ffc", 12'hFFC, 32'hB1);

      // Writes ignored, out-of-window reads zero
      apb_write("wr_fe0", 12'hFE0);
      apb_read("fe0_after_wr", 12'hFE0, 32'h31);
      apb_read("f00", 12'hF00, 32'h0);
      apb_read("fdc", 12'hFDC, 32'h0);

      // Glitch 1-0-1 across the sample window (2-flop delay: drive 3 cycles ahead)
      do_reset(1'b1);
      for (int e = 1; e <= 19; e++) begin
         cyc();
         if (e == 15) rev = 1'b0;
         if (e == 16) rev = 1'b1;
      end
      chk("glitch101_rv", 32'(rv), 32'h1);
      apb_read("glitch101_fe8", 12'hFE8, 32'h14);

      // Glitch 0-1-0 votes to 0; later toggles ignored
      do_reset(1'b0);
      for (int e = 1; e <= 19; e++) begin
         cyc();
         if (e == 15) rev = 1'b1;
         if (e == 16) rev = 1'b0;
      end
      chk("glitch010_rv", 32'(rv), 32'h1);
      apb_read("glitch010_fe8", 12'hFE8, 32'h04);
      rev = 1'b1;
      repeat (6) cyc();
      apb_read("post_lock_toggle_fe8", 12'hFE8, 32'h04);

      // Reset during SAMPLE, then a pre-lock read and a full re-settle
      do_reset(1'b1);
      repeat (17) cyc();
      rst_n = 1'b0;
      #1;
      chk("midsample_rv", 32'(rv), 32'h0);
      repeat (2) cyc();
      rst_n = 1'b1;
      apb_read("prelock_fe8", 12'hFE8, 32'h04);
      wait_rv(2, n);
      chk("rerelease_rv_cycle", 32'(n), 32'd19);
      apb_read("relock_fe8", 12'hFE8, 32'h14);

`ifdef RTC_ID_WRERR_EN
      chk("wrerr_init", 32'(wr_err), 32'h0);
      apb_write("wrerr_wr", 12'hF00);
      chk("wrerr_set", 32'(wr_err), 32'h1);
      apb_read("wrerr_fec", 12'hFEC, 32'h100);
      chk("wrerr_clr", 32'(wr_err), 32'h0);
      apb_write("wrerr_wr2", 12'hFE0);
      chk("wrerr_adjacent", 32'(wr_err), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
